debounce: RTL and testbench
===========================

Name: debounce

Overview:
Conditions a raw asynchronous level input (switch, button, external control line) into a clean, clock-synchronous level. The input is synchronized into the clk domain, then accepted only after it has held a new value for COUNT consecutive enable ticks. Sits directly upstream of the utility edge detector. Output o drives that detector's input, which turns each accepted transition into a one-cycle pulse.

Parameters:
COUNT, 20, number of consecutive clken ticks the synchronized input must differ from o before o changes; legal range 1..65535.
SYNC, 2, number of synchronizer flops; legal range 2..3.
INIT, 1'b0, value loaded into o and all synchronizer flops at reset.

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
clken  input  1  debounce tick enable (e.g. 1 ms strobe); gates only the stability counter
i  input  1  raw asynchronous input
o  output  1  debounced, synchronous level
busy  output  1  high while the synchronized input differs from o (a qualification is in progress)

Behaviour:
- Reset (synchronous, rst=1 at clk edge), all simultaneously: synchronizer flops <= INIT, o <= INIT, cnt <= 0. busy=0 after reset. rst overrides all other activity, including a pending count.
- Synchronizer:
  - SYNC-stage shift register clocked every clk, not gated by clken.
  - s = last stage. Latency from i to s is SYNC clk edges.
- Counter:
  - cnt width = max(1, clog2(COUNT)).
  - Range 0..COUNT-1, never wraps.
- Per clk edge, when not in reset, in priority order:
  1. If s == o: cnt <= 0, o holds. This abandons any partial count immediately when the input bounces back.
  2. Else if clken and cnt == COUNT-1: o <= s, cnt <= 0.
  3. Else if clken: cnt <= cnt+1.
  4. Else: hold.
- busy = (s != o), combinational from registers; no glitch on i reaches busy except via s.
- Latency to accept a change: SYNC clk edges, plus COUNT clken ticks sampled while s != o. With clken tied high and SYNC=2, o changes on the (2+COUNT)th clk edge after i changes.
- COUNT=1: o follows s on the first clken edge after s differs.
- A bounce shorter than COUNT ticks never reaches o. Each return of s to o restarts qualification from 0.
- Both directions (0->1 and 1->0) are qualified identically.
- o changes at most once per COUNT clken ticks.
- X on i never propagates past reset-initialized flops in simulation after the first SYNC edges.

Decomposition:
- No shared package needed. COUNT width is derived locally via clog2.
- One natural sub-module: sync_chain (parameters SYNC, INIT; ports clk, rst, d, q). It holds the metastability flops. Reusable by other utilities needing plain level synchronization. Carries a synthesis async-register attribute on its flops.
- Counter and compare logic stay in debounce.

Test Plan:
1. COUNT=4, SYNC=2, INIT=0, clken=1: assert rst for 2 clks -> o=0, busy=0, cnt=0.
2. Same config, i 0->1 held -> busy rises after edge 2; o=1 at edge 6; busy=0 from edge 6.
3. Same config, i high for 3 cycles, then low -> o stays 0, busy pulses 3 cycles, cnt returns to 0; then i high held -> o=1 exactly 6 edges after the second rise.
4. COUNT=4, clken one cycle in 8, i 0->1 held -> o=1 on the 4th clken pulse after s=1; cnt holds between pulses.
5. COUNT=4, o=0, i high, rst asserted when cnt=2 -> o=0, cnt=0, sync=0 next edge; after release a full 2+4-tick qualification is required.
6. COUNT=1, INIT=1, clken=1, i low from reset release -> o=1 through reset; o=0 on edge 3 after i low is first sampled.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce utility and its synchronizer.
package debounce_pkg;

    // Per-edge decision taken by the qualification logic.
    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_CLEAR  = 2'd1,
        ACT_COUNT  = 2'd2,
        ACT_ACCEPT = 2'd3
    } dbn_act_e;

    // Stability counter width; at least one bit even for COUNT=1.
    function automatic int unsigned cnt_width(input int unsigned count);
        int unsigned w;
        w = $clog2(count);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_sync_chain.sv
// Plain level synchronizer: SYNC flops in series, reset to INIT.
module sync_chain #(
    parameter int unsigned SYNC = 2,
    parameter logic        INIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* async_reg = "true" *) logic [SYNC-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC{INIT}};
        end else begin
            sync_q <= {sync_q[SYNC-2:0], d};
        end
    end

    assign q = sync_q[SYNC-1];

endmodule

// File: rtl/debounce.sv
// Debouncer: synchronizes a raw level and accepts a change only after it
// has held for COUNT consecutive clken ticks.
module debounce
    import debounce_pkg::*;
#(
    parameter int unsigned COUNT = 20,
    parameter int unsigned SYNC  = 2,
    parameter logic        INIT  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clken,
    input  logic i,
    output logic o,
    output logic busy
);

    localparam int unsigned CNT_W = cnt_width(COUNT);

    logic             s;
    logic             o_q, o_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dbn_act_e         act;

    sync_chain #(
        .SYNC (SYNC),
        .INIT (INIT)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (i),
        .q   (s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            o_q   <= INIT;
            cnt_q <= '0;
        end else begin
            o_q   <= o_d;
            cnt_q <= cnt_d;
        end
    end

    // A return of s to o abandons any partial qualification immediately.
    always_comb begin
        act   = ACT_HOLD;
        o_d   = o_q;
        cnt_d = cnt_q;
        if (s == o_q) begin
            act = ACT_CLEAR;
        end else if (clken && (cnt_q == CNT_W'(COUNT - 1))) begin
            act = ACT_ACCEPT;
        end else if (clken) begin
            act = ACT_COUNT;
        end
        case (act)
            ACT_CLEAR:  cnt_d = '0;
            ACT_ACCEPT: begin
                o_d   = s;
                cnt_d = '0;
            end
            ACT_COUNT:  cnt_d = cnt_q + CNT_W'(1);
            default:    cnt_d = cnt_q;
        endcase
    end

    assign o    = o_q;
    assign busy = (s != o_q);

endmodule

// File: tb/tb_debounce.sv
// Self-checking bench for debounce: three configurations, directed
// scenarios plus randomized traffic against a tick-counting reference.
module tb_debounce;

    logic       clk = 1'b0;
    logic [2:0] rst_v   = 3'b111;
    logic [2:0] clken_v = 3'b111;
    logic [2:0] i_v     = 3'b000;
    logic [2:0] o_w;
    logic [2:0] busy_w;

    int total = 0;
    int bad   = 0;

    int unsigned cnt_p  [3] = '{4, 1, 5};
    int unsigned sync_p [3] = '{2, 2, 3};
    logic        init_p [3] = '{1'b0, 1'b1, 1'b0};

    // Reference state: sample history (index 0 newest), accepted level, tick run.
    logic        hist  [3][3];
    logic        o_m   [3];
    logic        busy_m[3];
    int unsigned ticks [3];

    always #5 clk = ~clk;

    debounce #(.COUNT(4), .SYNC(2), .INIT(1'b0)) u0 (
        .clk(clk), .rst(rst_v[0]), .clken(clken_v[0]), .i(i_v[0]),
        .o(o_w[0]), .busy(busy_w[0]));

    debounce #(.COUNT(1), .SYNC(2), .INIT(1'b1)) u1 (
        .clk(clk), .rst(rst_v[1]), .clken(clken_v[1]), .i(i_v[1]),
        .o(o_w[1]), .busy(busy_w[1]));

    debounce #(.COUNT(5), .SYNC(3), .INIT(1'b0)) u2 (
        .clk(clk), .rst(rst_v[2]), .clken(clken_v[2]), .i(i_v[2]),
        .o(o_w[2]), .busy(busy_w[2]));

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // o flips once s has differed from it for COUNT clken ticks in a row.
    task automatic model_edge();
        logic s_old;
        for (int k = 0; k < 3; k++) begin
            s_old = hist[k][sync_p[k]-1];
            if (rst_v[k]) begin
                for (int j = 0; j < 3; j++) hist[k][j] = init_p[k];
                o_m[k]   = init_p[k];
                ticks[k] = 0;
            end else begin
                if (s_old == o_m[k]) begin
                    ticks[k] = 0;
                end else if (clken_v[k]) begin
                    ticks[k]++;
                    if (ticks[k] == cnt_p[k]) begin
                        o_m[k]   = s_old;
                        ticks[k] = 0;
                    end
                end
                for (int j = 2; j > 0; j--) hist[k][j] = hist[k][j-1];
                hist[k][0] = i_v[k];
            end
            busy_m[k] = (hist[k][sync_p[k]-1] != o_m[k]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d.o", k), o_w[k], o_m[k]);
            chk($sformatf("u%0d.busy", k), busy_w[k], busy_m[k]);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) hist[k][j] = init_p[k];
            o_m[k] = init_p[k]; busy_m[k] = 1'b0; ticks[k] = 0;
        end

        // Reset: u0 and u1 both held with their raw inputs low.
        rst_v = 3'b111; clken_v = 3'b111; i_v = 3'b000;
        step(); step();
        chk("rst.u0.o", o_w[0], 1'b0);
        chk("rst.u0.busy", busy_w[0], 1'b0);
        chk("rst.u1.o", o_w[1], 1'b1);
        chk("rst.u1.busy", busy_w[1], 1'b0);

        // u0 rising edge (COUNT=4) and u1 falling edge (COUNT=1) together.
        rst_v[0] = 1'b0; rst_v[1] = 1'b0; i_v[0] = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            chk($sformatf("rise.o.e%0d", e), o_w[0], 1'(e >= 6));
            chk($sformatf("rise.busy.e%0d", e), busy_w[0], 1'(e >= 2 && e < 6));
            chk($sformatf("c1.o.e%0d", e), o_w[1], 1'(e < 3));
        end

        // Short bounce never reaches o; a later held rise qualifies in full.
        rst_v[0] = 1'b1; i_v[0] = 1'b0; step(); step();
        rst_v[0] = 1'b0; i_v[0] = 1'b1;
        for (int e = 1; e <= 3; e++) step();
        i_v[0] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk($sformatf("bounce.o.e%0d", e), o_w[0], 1'b0);
        end
        i_v[0] = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            chk($sformatf("requal.o.e%0d", e), o_w[0], 1'(e == 6));
        end

        // Sparse clken: one tick in eight; accept on the fourth tick after s=1.
        rst_v[0] = 1'b1; i_v[0] = 1'b0; step(); step();
        rst_v[0] = 1'b0; i_v[0] = 1'b1;
        for (int c = 0; c < 48; c++) begin
            clken_v[0] = 1'((c % 8) == 7);
            step();
            chk($sformatf("sparse.o.c%0d", c), o_w[0], 1'(c >= 31));
        end
        clken_v[0] = 1'b1;

        // Reset mid-count discards the partial count and the synchronizer.
        rst_v[0] = 1'b1; i_v[0] = 1'b0; step(); step();
        rst_v[0] = 1'b0; i_v[0] = 1'b1;
        for (int e = 1; e <= 4; e++) step();
        rst_v[0] = 1'b1;
        step();
        chk("midrst.o", o_w[0], 1'b0);
        chk("midrst.busy", busy_w[0], 1'b0);
        rst_v[0] = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            step();
            chk($sformatf("postrst.o.e%0d", e), o_w[0], 1'(e == 6));
        end

        // Randomized traffic on all three instances.
        rst_v = 3'b000;
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(3) == 0) i_v[k] = ~i_v[k];
                clken_v[k] = 1'($urandom_range(1));
                rst_v[k]   = 1'($urandom_range(63) == 0);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
